// File: rtl/snake_direction_ctrl.sv
// Snake game direction controller: debounces four buttons, latches one pending turn,
// and commits it on the upstream move tick with a registered strobe.
`timescale 1ns/1ps
module snake_direction_ctrl #(
   parameter int         DEBOUNCE_WIDTH = 20,
   parameter int         DEBOUNCE_MAX   = 999999,
   parameter logic [1:0] INIT_DIR       = 2'b11
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BTN_U,
   input  logic       BTN_D,
   input  logic       BTN_L,
   input  logic       BTN_R,
   input  logic       MOVE_TICK,
   output logic [1:0] DIRECTION,
   output logic       MOVE_STROBE,
   output logic       DIR_CHANGED
);

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   localparam logic [DEBOUNCE_WIDTH-1:0] CNT_MAX = DEBOUNCE_WIDTH'(DEBOUNCE_MAX);
   localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ONE = DEBOUNCE_WIDTH'(1);

   // Opposite headings differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
   function automatic dir_t oppositeOf(input dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

   logic [3:0]                w_btnRaw;
   logic [3:0]                r_sync1;
   logic [3:0]                r_sync2;
   logic [3:0]                r_stable;
   logic [3:0]                r_stablePrev;
   logic [DEBOUNCE_WIDTH-1:0] r_cnt [4];
   logic [3:0]                w_press;

   logic                      w_reqValid;
   dir_t                      w_reqDir;
   logic                      w_accept;
   logic                      w_commitOk;

   dir_t                      r_dir;
   logic                      r_pendValid;
   dir_t                      r_pendDir;
   logic                      r_strobe;
   logic                      r_changed;

   dir_t                      w_dirNext;
   logic                      w_pendValidNext;
   dir_t                      w_pendDirNext;
   logic                      w_changedNext;

   assign w_btnRaw = {BTN_R, BTN_L, BTN_D, BTN_U};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_sync1      <= '0;
         r_sync2      <= '0;
         r_stable     <= '0;
         r_stablePrev <= '0;
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1      <= w_btnRaw;
         r_sync2      <= r_sync1;
         r_stablePrev <= r_stable;
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Only rising edges of the debounced level are requests; releases are ignored.
   assign w_press = r_stable & ~r_stablePrev;

   always_comb begin
      w_reqValid = 1'b1;
      w_reqDir   = DIR_UP;
      if (w_press[0]) begin
         w_reqDir = DIR_UP;
      end else if (w_press[1]) begin
         w_reqDir = DIR_DOWN;
      end else if (w_press[2]) begin
         w_reqDir = DIR_LEFT;
      end else if (w_press[3]) begin
         w_reqDir = DIR_RIGHT;
      end else begin
         w_reqValid = 1'b0;
      end
   end

   assign w_accept   = w_reqValid && (w_reqDir != r_dir) && (w_reqDir != oppositeOf(r_dir));
   // A request accepted on a tick cycle was checked against the old heading, so re-check here.
   assign w_commitOk = r_pendValid && (r_pendDir != oppositeOf(r_dir));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_dir       <= dir_t'(INIT_DIR);
         r_pendValid <= 1'b0;
         r_pendDir   <= dir_t'(INIT_DIR);
         r_strobe    <= 1'b0;
         r_changed   <= 1'b0;
      end else begin
         r_dir       <= w_dirNext;
         r_pendValid <= w_pendValidNext;
         r_pendDir   <= w_pendDirNext;
         r_strobe    <= MOVE_TICK;
         r_changed   <= w_changedNext;
      end
   end

   always_comb begin
      w_dirNext       = r_dir;
      w_pendValidNext = r_pendValid;
      w_pendDirNext   = r_pendDir;
      w_changedNext   = 1'b0;
      if (MOVE_TICK) begin
         w_pendValidNext = 1'b0;
         if (w_commitOk) begin
            w_dirNext     = r_pendDir;
            w_changedNext = (r_pendDir != r_dir);
         end
      end
      if (w_accept) begin
         w_pendValidNext = 1'b1;
         w_pendDirNext   = w_reqDir;
      end
   end

   assign DIRECTION   = r_dir;
   assign MOVE_STROBE = r_strobe;
   assign DIR_CHANGED = r_changed;

endmodule

// File: tb/tb_snake_direction_ctrl.sv
// Directed bench for snake_direction_ctrl: each tick pushes its expected strobe
// outcome to a queue that a per-cycle checker pops when the strobe is due.
`timescale 1ns/1ps
module tb_snake_direction_ctrl;

   typedef struct {
      int         cyc;
      logic [1:0] dir;
      logic       chg;
   } exp_t;

   logic       CLK;
   logic       RESET;
   logic [3:0] btn;
   logic       MOVE_TICK;
   logic [1:0] DIRECTION;
   logic       MOVE_STROBE;
   logic       DIR_CHANGED;

   exp_t       expQ[$];
   logic [1:0] expDir;
   int         cycleCount;
   int         compared;
   int         mismatched;

   snake_direction_ctrl #(
      .DEBOUNCE_WIDTH(4),
      .DEBOUNCE_MAX  (3),
      .INIT_DIR      (2'b11)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .BTN_U      (btn[0]),
      .BTN_D      (btn[1]),
      .BTN_L      (btn[2]),
      .BTN_R      (btn[3]),
      .MOVE_TICK  (MOVE_TICK),
      .DIRECTION  (DIRECTION),
      .MOVE_STROBE(MOVE_STROBE),
      .DIR_CHANGED(DIR_CHANGED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cycleCount <= cycleCount + 1;

   // Called at each falling edge; a queued entry is due one cycle after its tick was driven.
   task automatic checkOutput();
      logic expStrobe;
      exp_t e;
      if (RESET !== 1'b0) return;
      expStrobe = (expQ.size() > 0) && (expQ[0].cyc < cycleCount);
      compared++;
      assert (MOVE_STROBE === expStrobe) else begin
         mismatched++;
         $error("[TB] FAIL strobe @cyc %0d: observed=%b expected=%b", cycleCount, MOVE_STROBE, expStrobe);
      end
      if (expStrobe) begin
         e = expQ.pop_front();
         expDir = e.dir;
         compared++;
         assert (DIRECTION === e.dir) else begin
            mismatched++;
            $error("[TB] FAIL dirAtStrobe @cyc %0d: observed=%b expected=%b", cycleCount, DIRECTION, e.dir);
         end
         compared++;
         assert (DIR_CHANGED === e.chg) else begin
            mismatched++;
            $error("[TB] FAIL dirChanged @cyc %0d: observed=%b expected=%b", cycleCount, DIR_CHANGED, e.chg);
         end
      end else begin
         compared++;
         assert (DIRECTION === expDir) else begin
            mismatched++;
            $error("[TB] FAIL dirHold @cyc %0d: observed=%b expected=%b", cycleCount, DIRECTION, expDir);
         end
         compared++;
         assert (DIR_CHANGED === 1'b0) else begin
            mismatched++;
            $error("[TB] FAIL changedIdle @cyc %0d: observed=%b expected=0", cycleCount, DIR_CHANGED);
         end
      end
   endtask

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic tick(input logic [1:0] dir, input logic chg);
      exp_t e;
      MOVE_TICK = 1'b1;
      e.cyc = cycleCount;
      e.dir = dir;
      e.chg = chg;
      expQ.push_back(e);
      idle(1);
      MOVE_TICK = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 5 && expQ.size() != 0; i++) idle(1);
      compared++;
      assert (expQ.size() == 0) else begin
         mismatched++;
         $error("[TB] FAIL drain %s: observed=%0d pending expected=0", tag, expQ.size());
         expQ.delete();
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input int hold, input int settle);
      btn = mask;
      idle(hold);
      btn = 4'b0000;
      idle(settle);
   endtask

   initial begin
      RESET      = 1'b1;
      btn        = 4'b0000;
      MOVE_TICK  = 1'b0;
      expDir     = 2'b11;
      cycleCount = 0;
      compared   = 0;
      mismatched = 0;
      fork
         forever begin
            @(negedge CLK);
            checkOutput();
         end
      join_none
      idle(3);
      RESET = 1'b0;

      $display("[TB] idle tick after reset");
      idle(10);
      tick(2'b11, 1'b0);
      idle(9);
      drain("idle");

      $display("[TB] UP held, then a second tick");
      applyStimulus(4'b0001, 10, 10);
      tick(2'b00, 1'b1);
      idle(3);
      tick(2'b00, 1'b0);
      drain("up");

      $display("[TB] back to RIGHT, then opposite LEFT rejected");
      applyStimulus(4'b1000, 8, 10);
      tick(2'b11, 1'b1);
      applyStimulus(4'b0100, 8, 10);
      tick(2'b11, 1'b0);
      drain("opposite");

      $display("[TB] short DOWN glitches");
      for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 3, 3);
      idle(8);
      tick(2'b11, 1'b0);
      drain("glitch");

      $display("[TB] last request wins, then priority U over L");
      applyStimulus(4'b0001, 8, 10);
      applyStimulus(4'b0010, 8, 10);
      tick(2'b01, 1'b1);
      applyStimulus(4'b0101, 8, 10);
      tick(2'b01, 1'b0);
      drain("priority");

      $display("[TB] reset discards pending UP");
      applyStimulus(4'b0100, 8, 10);
      tick(2'b10, 1'b1);
      applyStimulus(4'b0001, 8, 10);
      RESET  = 1'b1;
      expQ.delete();
      expDir = 2'b11;
      idle(1);
      RESET  = 1'b0;
      tick(2'b11, 1'b0);
      idle(2);
      tick(2'b11, 1'b0);
      drain("reset");

      $display("[TB] back-to-back ticks");
      tick(2'b11, 1'b0);
      tick(2'b11, 1'b0);
      drain("b2b");

      $display("[TB] DOWN pulse of exactly four cycles");
      applyStimulus(4'b0010, 4, 10);
      tick(2'b01, 1'b1);
      drain("minpulse");

      idle(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
